// File: rtl/pkt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pkt_ctrl_pkg
// Shared types and constants for the packet-sequencing controller:
//   - state_e    : controller states
//   - MBOX_FWD   : mailbox verdict bit that forwards the packet
//   - MBOX_DROP  : mailbox verdict bit that discards the packet (wins over FWD)
//   - CNT_WIDTH  : width of the saturating statistics counters
//   - sat_inc()  : increment that sticks at all-ones
// -----------------------------------------------------------------------------
package pkt_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_PROC  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DROP  = 3'd4
    } state_e;

    localparam int MBOX_FWD  = 0;
    localparam int MBOX_DROP = 1;

    localparam int CNT_WIDTH = 32;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/pkt_framer.sv
// -----------------------------------------------------------------------------
// pkt_framer
// Tracks packet framing on the upstream write side.
//   clk, reset  : clock, synchronous active-high reset
//   in_wr       : upstream write strobe (mirrors FIFO wea)
//   in_ctrl     : ctrl byte of the written word
//   accept      : write accepted by the controller (in_wr & in_rdy)
//   idle        : controller is waiting for a new packet
//   frame_end   : this accepted write closes the packet (EOP or length limit)
//   trunc       : packet closed by the length limit, not by a real EOP
//   head_addr   : SRAM address of the current packet's first word
//   pkt_len     : word count of the current packet
// The write pointer follows every in_wr, accepted or not, because the FIFO
// stores every word it is handed; head_addr therefore stays a true SRAM address.
// -----------------------------------------------------------------------------
module pkt_framer
    import pkt_ctrl_pkg::*;
#(
    parameter int CTRL_WIDTH    = 8,
    parameter int AWIDTH        = 10,
    parameter int MAX_PKT_WORDS = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_wr,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic              accept,
    input  logic              idle,
    output logic              frame_end,
    output logic              trunc,
    output logic [AWIDTH-1:0] head_addr,
    output logic [AWIDTH-1:0] pkt_len
);

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] head_addr_q, head_addr_d;
    logic [AWIDTH-1:0] pkt_len_q, pkt_len_d;
    logic              seen_payload_q, seen_payload_d;

    logic is_payload;
    logic eop;
    logic len_hit;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        head_addr_d    = head_addr_q;
        pkt_len_d      = pkt_len_q;
        seen_payload_d = seen_payload_q;

        is_payload = (in_ctrl == '0);
        // EOP needs at least one payload word earlier in this packet, so the
        // very first word of a packet can never be EOP.
        eop = accept & ~idle & ~is_payload & seen_payload_q;

        if (in_wr) begin
            wr_ptr_d = wr_ptr_q + AWIDTH'(1);
        end

        if (accept) begin
            if (idle) begin
                head_addr_d    = wr_ptr_q;
                pkt_len_d      = AWIDTH'(1);
                seen_payload_d = is_payload;
            end else begin
                pkt_len_d      = pkt_len_q + AWIDTH'(1);
                seen_payload_d = seen_payload_q | is_payload;
            end
        end

        len_hit   = accept & (pkt_len_d == AWIDTH'(MAX_PKT_WORDS));
        frame_end = eop | len_hit;
        trunc     = len_hit & ~eop;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    // NOTE: reset is synchronous; it is only seen at a rising clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            head_addr_q    <= '0;
            pkt_len_q      <= '0;
            seen_payload_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            head_addr_q    <= head_addr_d;
            pkt_len_q      <= pkt_len_d;
            seen_payload_q <= seen_payload_d;
        end
    end

    assign head_addr = head_addr_q;
    assign pkt_len   = pkt_len_q;

endmodule

// File: rtl/pkt_proc_ctrl.sv
// -----------------------------------------------------------------------------
// pkt_proc_ctrl
// Sequences one packet at a time between the packet FIFO/SRAM and the core:
// receive a packet, freeze input and run the core, wait for the mailbox verdict
// (or a timeout), then drain the packet downstream or discard it, and rearm.
//   clk, reset                 : clock, synchronous active-high reset
//   in_wr, in_ctrl, in_rdy     : upstream write side
//   fifo_almfull, fifo_empty   : FIFO status
//   out_rdy, fifo_reb, out_wr  : downstream read side
//   pc_en, core_reset          : core run control (registered)
//   core_mem_we/addr/data      : core writes to SRAM port B (mailbox snoop)
//   head_addr, pkt_len         : current packet location and size
//   pkt_cnt, drop_cnt, err_cnt : saturating statistics
// -----------------------------------------------------------------------------
module pkt_proc_ctrl
    import pkt_ctrl_pkg::*;
#(
    parameter int                CTRL_WIDTH     = 8,
    parameter int                AWIDTH         = 10,
    parameter int                MAX_PKT_WORDS  = 1000,
    parameter logic [AWIDTH-1:0] MBOX_ADDR      = 10'h3FF,
    parameter int                TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_wr,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  in_rdy,
    input  logic                  fifo_almfull,
    input  logic                  fifo_empty,
    input  logic                  out_rdy,
    output logic                  fifo_reb,
    output logic                  out_wr,
    output logic                  pc_en,
    output logic                  core_reset,
    input  logic                  core_mem_we,
    input  logic [AWIDTH-1:0]     core_mem_addr,
    input  logic [63:0]           core_mem_data,
    output logic [AWIDTH-1:0]     head_addr,
    output logic [AWIDTH-1:0]     pkt_len,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e state_q, state_d;

    logic [15:0]          timer_q, timer_d;
    logic [AWIDTH-1:0]    rem_q, rem_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                 pc_en_q, pc_en_d;
    logic                 core_reset_q, core_reset_d;

    logic accept;
    logic wr_err;
    logic frame_end;
    logic trunc;
    logic mbox_hit;
    logic last_read;

    // Only the two verdict bits of the mailbox word carry meaning.
    logic unused_core_data;
    assign unused_core_data = ^core_mem_data[63:2];

    pkt_framer #(
        .CTRL_WIDTH    (CTRL_WIDTH),
        .AWIDTH        (AWIDTH),
        .MAX_PKT_WORDS (MAX_PKT_WORDS)
    ) u_framer (
        .clk       (clk),
        .reset     (reset),
        .in_wr     (in_wr),
        .in_ctrl   (in_ctrl),
        .accept    (accept),
        .idle      (state_q == ST_IDLE),
        .frame_end (frame_end),
        .trunc     (trunc),
        .head_addr (head_addr),
        .pkt_len   (pkt_len)
    );

    // Handshakes are combinational from state and inputs. They are held low
    // while reset is asserted, since the FIFO is being cleared in that cycle.
    always_comb begin
        in_rdy   = 1'b0;
        fifo_reb = 1'b0;
        out_wr   = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE, ST_RECV: in_rdy = ~fifo_almfull;
                ST_DRAIN: begin
                    fifo_reb = out_rdy & ~fifo_empty;
                    out_wr   = fifo_reb;
                end
                ST_DROP:  fifo_reb = ~fifo_empty;
                default:  ;
            endcase
        end
        accept = in_wr & in_rdy;
        wr_err = in_wr & ~in_rdy;
    end

    assign mbox_hit  = core_mem_we & (core_mem_addr == MBOX_ADDR);
    // Leave DRAIN/DROP on the edge that performs the final read, so a full-rate
    // drain spends exactly pkt_len cycles in the state.
    assign last_read = (rem_q == '0) | (fifo_reb & (rem_q == AWIDTH'(1)));

    always_comb begin
        state_d    = state_q;
        timer_d    = '0;
        rem_d      = rem_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = frame_end ? ST_PROC : ST_RECV;
                end
            end
            ST_RECV: begin
                if (accept && frame_end) begin
                    state_d = ST_PROC;
                end
            end
            ST_PROC: begin
                timer_d = timer_q + 16'd1;
                // A deciding mailbox write beats the timeout in the same cycle;
                // a mailbox write with neither bit set leaves the timer running.
                if (mbox_hit && core_mem_data[MBOX_DROP]) begin
                    state_d = ST_DROP;
                    rem_d   = pkt_len;
                end else if (mbox_hit && core_mem_data[MBOX_FWD]) begin
                    state_d = ST_DRAIN;
                    rem_d   = pkt_len;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ST_DROP;
                    rem_d   = pkt_len;
                end
            end
            ST_DRAIN: begin
                if (fifo_reb) begin
                    rem_d = rem_q - AWIDTH'(1);
                end
                if (last_read) begin
                    state_d   = ST_IDLE;
                    rem_d     = '0;
                    pkt_cnt_d = sat_inc(pkt_cnt_q);
                end
            end
            ST_DROP: begin
                if (fifo_reb) begin
                    rem_d = rem_q - AWIDTH'(1);
                end
                if (last_read) begin
                    state_d    = ST_IDLE;
                    rem_d      = '0;
                    drop_cnt_d = sat_inc(drop_cnt_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An unaccepted write and a truncating write cannot share a cycle.
        if (wr_err || trunc) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end

        // Registered core controls follow the next state so they change on the
        // same edge as the state register.
        pc_en_d      = (state_d == ST_PROC);
        core_reset_d = ~pc_en_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            rem_q        <= '0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            err_cnt_q    <= '0;
            pc_en_q      <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            rem_q        <= rem_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            err_cnt_q    <= err_cnt_d;
            pc_en_q      <= pc_en_d;
            core_reset_q <= core_reset_d;
        end
    end

    assign pc_en      = pc_en_q;
    assign core_reset = core_reset_q;
    assign pkt_cnt    = pkt_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_pkt_proc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pkt_proc_ctrl
// Directed bench for pkt_proc_ctrl with a small behavioural FIFO that supplies
// fifo_empty and logs the ctrl bytes of every word popped with out_wr.
// -----------------------------------------------------------------------------
module tb_pkt_proc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_wr;
    logic [7:0]  in_ctrl;
    logic        in_rdy;
    logic        fifo_almfull;
    logic        fifo_empty;
    logic        out_rdy;
    logic        fifo_reb;
    logic        out_wr;
    logic        pc_en;
    logic        core_reset;
    logic        core_mem_we;
    logic [9:0]  core_mem_addr;
    logic [63:0] core_mem_data;
    logic [9:0]  head_addr;
    logic [9:0]  pkt_len;
    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;
    logic [31:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pkt_proc_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .in_wr         (in_wr),
        .in_ctrl       (in_ctrl),
        .in_rdy        (in_rdy),
        .fifo_almfull  (fifo_almfull),
        .fifo_empty    (fifo_empty),
        .out_rdy       (out_rdy),
        .fifo_reb      (fifo_reb),
        .out_wr        (out_wr),
        .pc_en         (pc_en),
        .core_reset    (core_reset),
        .core_mem_we   (core_mem_we),
        .core_mem_addr (core_mem_addr),
        .core_mem_data (core_mem_data),
        .head_addr     (head_addr),
        .pkt_len       (pkt_len),
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt),
        .err_cnt       (err_cnt)
    );

    // Behavioural FIFO: stores ctrl bytes, reset together with the DUT.
    logic [7:0]  fifo_mem [0:1023];
    logic [9:0]  f_wp, f_rp;
    logic [10:0] f_cnt;
    logic [7:0]  out_log [0:255];
    int          total_out;
    logic        f_pop;

    assign f_pop      = fifo_reb && (f_cnt != 11'd0);
    assign fifo_empty = (f_cnt == 11'd0);

    always @(posedge clk) begin
        if (reset) begin
            f_wp      <= '0;
            f_rp      <= '0;
            f_cnt     <= '0;
            total_out <= 0;
        end else begin
            if (in_wr) begin
                fifo_mem[f_wp] <= in_ctrl;
                f_wp           <= f_wp + 10'd1;
            end
            if (f_pop) begin
                f_rp <= f_rp + 10'd1;
                if (out_wr) begin
                    out_log[total_out % 256] <= fifo_mem[f_rp];
                    total_out                <= total_out + 1;
                end
            end
            f_cnt <= f_cnt + 11'(in_wr) - 11'(f_pop);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] c);
        in_wr   = 1'b1;
        in_ctrl = c;
        tick();
        in_wr   = 1'b0;
        in_ctrl = 8'h00;
    endtask

    // 2 header words, 3 payload words, EOP.
    task automatic send_std_pkt();
        send_word(8'hFF);
        send_word(8'hFF);
        send_word(8'h00);
        send_word(8'h00);
        send_word(8'h00);
        send_word(8'h0F);
    endtask

    task automatic core_write(input logic [9:0] addr, input logic [63:0] data);
        core_mem_we   = 1'b1;
        core_mem_addr = addr;
        core_mem_data = data;
        tick();
        core_mem_we   = 1'b0;
        core_mem_addr = '0;
        core_mem_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_wr = 1'b0;
        core_mem_we = 1'b0;
        out_rdy = 1'b1;
        fifo_almfull = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Bounded wait for the return to IDLE (in_rdy high with almfull low).
    task automatic wait_idle(input string tag, output int cycles);
        cycles = 0;
        while (!in_rdy && cycles < 200) begin
            tick();
            cycles++;
        end
        check(tag, in_rdy, 1'b1);
    endtask

    function automatic logic [47:0] last6(input int first);
        logic [47:0] s;
        s = '0;
        for (int i = 0; i < 6; i++) s = {s[39:0], out_log[(first + i) % 256]};
        return s;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int out0;

        reset = 1'b1; in_wr = 1'b0; in_ctrl = '0; fifo_almfull = 1'b0;
        out_rdy = 1'b1; core_mem_we = 1'b0; core_mem_addr = '0; core_mem_data = '0;

        // Reset values, sampled while reset is still held.
        tick();
        tick();
        check("rst_in_rdy", in_rdy, 1'b0);
        check("rst_fifo_reb", fifo_reb, 1'b0);
        check("rst_out_wr", out_wr, 1'b0);
        check("rst_pc_en", pc_en, 1'b0);
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_head_addr", head_addr, 10'd0);
        check("rst_pkt_len", pkt_len, 10'd0);
        check("rst_counters", {pkt_cnt, drop_cnt, err_cnt}, 96'd0);
        reset = 1'b0;
        tick();
        check("post_rst_in_rdy", in_rdy, 1'b1);

        // Forward: 6-word packet, verdict 1.
        send_word(8'hFF);
        check("t1_len_after_sop", pkt_len, 10'd1);
        check("t1_recv_pc_en", pc_en, 1'b0);
        send_word(8'hFF);
        send_word(8'h00);
        send_word(8'h00);
        send_word(8'h00);
        send_word(8'h0F);
        check("t1_proc_in_rdy", in_rdy, 1'b0);
        check("t1_proc_pc_en", pc_en, 1'b1);
        check("t1_proc_core_reset", core_reset, 1'b0);
        check("t1_head_addr", head_addr, 10'd0);
        check("t1_pkt_len", pkt_len, 10'd6);
        tick();
        tick();
        out0 = total_out;
        core_write(10'h3FF, 64'h1);
        check("t1_drain_pc_en", pc_en, 1'b0);
        check("t1_drain_core_reset", core_reset, 1'b1);
        check("t1_drain_reb", fifo_reb, 1'b1);
        wait_idle("t1_idle", cyc);
        check("t1_drain_cycles", cyc, 6);
        check("t1_out_pulses", total_out - out0, 6);
        check("t1_out_order", last6(out0), 48'hFFFF0000000F);
        check("t1_pkt_cnt", pkt_cnt, 32'd1);
        check("t1_drop_cnt", drop_cnt, 32'd0);
        check("t1_err_cnt", err_cnt, 32'd0);

        // Drop verdict on a second packet; ignored core writes first.
        send_std_pkt();
        check("t2_head_addr", head_addr, 10'd6);
        check("t2_pkt_len", pkt_len, 10'd6);
        core_write(10'h3FE, 64'h2);
        core_write(10'h3FF, 64'h0);
        check("t2_ignored_pc_en", pc_en, 1'b1);
        out0 = total_out;
        core_write(10'h3FF, 64'h2);
        check("t2_drop_reb", fifo_reb, 1'b1);
        check("t2_drop_out_wr", out_wr, 1'b0);
        wait_idle("t2_idle", cyc);
        check("t2_out_pulses", total_out - out0, 0);
        check("t2_fifo_empty", fifo_empty, 1'b1);
        check("t2_drop_cnt", drop_cnt, 32'd1);
        check("t2_pkt_cnt", pkt_cnt, 32'd1);

        // Timeout: pc_en high for exactly 4096 cycles, then drop.
        do_reset();
        send_std_pkt();
        cyc = 0;
        while (pc_en === 1'b1 && cyc < 5000) begin
            tick();
            cyc++;
        end
        check("t3_pc_en_cycles", cyc, 4096);
        check("t3_drop_reb", fifo_reb, 1'b1);
        wait_idle("t3_idle", cyc);
        check("t3_drop_cnt", drop_cnt, 32'd1);
        check("t3_pkt_cnt", pkt_cnt, 32'd0);

        // Mailbox in the last PROC cycle beats the timeout.
        do_reset();
        send_std_pkt();
        repeat (4095) tick();
        check("t4_still_proc", pc_en, 1'b1);
        core_write(10'h3FF, 64'h1);
        check("t4_drain_out_wr", out_wr, 1'b1);
        wait_idle("t4_idle", cyc);
        check("t4_pkt_cnt", pkt_cnt, 32'd1);
        check("t4_drop_cnt", drop_cnt, 32'd0);

        // Drain with out_rdy toggling 1/0 each cycle: 6 words over 11 cycles.
        do_reset();
        send_std_pkt();
        out0 = total_out;
        core_write(10'h3FF, 64'h1);
        cyc = 0;
        while (!in_rdy && cyc < 50) begin
            tick();
            cyc++;
            out_rdy = ~out_rdy;
        end
        out_rdy = 1'b1;
        check("t5_drain_cycles", cyc, 11);
        check("t5_out_pulses", total_out - out0, 6);
        check("t5_out_order", last6(out0), 48'hFFFF0000000F);
        check("t5_pkt_cnt", pkt_cnt, 32'd1);

        // Truncation at 1000 words, writes during PROC, then reset in PROC.
        do_reset();
        repeat (1000) send_word(8'h00);
        check("t6_trunc_pc_en", pc_en, 1'b1);
        check("t6_trunc_in_rdy", in_rdy, 1'b0);
        check("t6_trunc_len", pkt_len, 10'd1000);
        check("t6_trunc_err", err_cnt, 32'd1);
        in_wr = 1'b1;
        repeat (3) tick();
        in_wr = 1'b0;
        check("t6_proc_wr_err", err_cnt, 32'd4);
        check("t6_proc_len_held", pkt_len, 10'd1000);
        reset = 1'b1;
        tick();
        check("t6_rst_pc_en", pc_en, 1'b0);
        check("t6_rst_core_reset", core_reset, 1'b1);
        check("t6_rst_counters", {pkt_cnt, drop_cnt, err_cnt}, 96'd0);
        check("t6_rst_len_head", {pkt_len, head_addr}, 20'd0);
        reset = 1'b0;
        tick();
        check("t6_idle_in_rdy", in_rdy, 1'b1);

        // Almost-full blocks input; a write anyway is an error, not counted.
        fifo_almfull = 1'b1;
        #1;
        check("t7_almfull_in_rdy", in_rdy, 1'b0);
        send_word(8'hFF);
        check("t7_err_cnt", err_cnt, 32'd1);
        check("t7_pkt_len", pkt_len, 10'd0);
        fifo_almfull = 1'b0;
        #1;
        check("t7_in_rdy_back", in_rdy, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pkt_proc_ctrl.md
# pkt_proc_ctrl

Packet-sequencing controller between the packet FIFO/SRAM (`fifo_sram`) and the RISC-V `datapath` core. It counts one packet into the FIFO, then freezes input and enables the core (`pc_en`). It waits for the core to post a verdict to a mailbox address, or for a timeout. It then drains the packet downstream or discards it, and rearms. It replaces the hand-driven `pc_en`/`in_rdy`/`reb` glue currently tied off at the top level.

## Interface
- `CTRL_WIDTH`, 8: width of the ctrl byte per 64-bit word.
- `AWIDTH`, 10: SRAM/FIFO address width (1024 words).
- `MAX_PKT_WORDS`, 1000: largest accepted packet, in words.
- `MBOX_ADDR`, 10'h3FF: SRAM word address the core writes its verdict to.
- `TIMEOUT_CYCLES`, 4096: maximum cycles in PROC; counter is 16 bits.

- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `in_wr`, in, 1: upstream word write (also drives FIFO `wea`).
- `in_ctrl`, in, CTRL_WIDTH: ctrl byte of the written word.
- `in_rdy`, out, 1: upstream may write.
- `fifo_almfull`, in, 1: FIFO almost full.
- `fifo_empty`, in, 1: FIFO empty.
- `out_rdy`, in, 1: downstream ready.
- `fifo_reb`, out, 1: FIFO read enable.
- `out_wr`, out, 1: downstream word valid.
- `pc_en`, out, 1: core run enable.
- `core_reset`, out, 1: holds the core in reset while not in PROC.
- `core_mem_we`, in, 1: core write strobe to SRAM port B.
- `core_mem_addr`, in, AWIDTH: core write address.
- `core_mem_data`, in, 64: core write data.
- `head_addr`, out, AWIDTH: SRAM address of the current packet's first word.
- `pkt_len`, out, AWIDTH: word count of the current packet.
- `pkt_cnt`, out, 32: packets forwarded.
- `drop_cnt`, out, 32: packets dropped, including timeouts.
- `err_cnt`, out, 32: protocol errors.

## Operation
Framing:
- Header words have `in_ctrl` != 0 before any payload word.
- Payload words have `in_ctrl` == 0.
- EOP is the first word with `in_ctrl` != 0 that follows at least one word with `in_ctrl` == 0.

States:
- IDLE
  - `in_rdy` = ~`fifo_almfull`.
  - The first accepted write latches `head_addr` from the internal write pointer (wraps mod 2^AWIDTH) and moves to RECV; `pkt_len` = 1.
- RECV
  - `in_rdy` = ~`fifo_almfull`; each accepted write increments `pkt_len`.
  - EOP write -> PROC.
  - `pkt_len` reaching MAX_PKT_WORDS without EOP is treated as EOP (truncation): `err_cnt`++, -> PROC.
- PROC
  - `in_rdy` = 0, `core_reset` = 0, `pc_en` = 1; the timeout counter runs.
  - A core write with `core_mem_we` & `core_mem_addr` == MBOX_ADDR decides the packet: `core_mem_data[1]` = 1 -> DROP; else `core_mem_data[0]` = 1 -> DRAIN. A mailbox write with both bits 0 is ignored.
  - Counter reaching TIMEOUT_CYCLES-1 -> DROP.
- DRAIN
  - `fifo_reb` = `out_rdy` & ~`fifo_empty`; `out_wr` = `fifo_reb`; the remaining count decrements on each read.
  - Count 0 -> IDLE, `pkt_cnt`++.
- DROP
  - `fifo_reb` = ~`fifo_empty`; `out_wr` = 0; count decrements on each read.
  - Count 0 -> IDLE, `drop_cnt`++.

Boundary rules:
- `in_wr` while `in_rdy` = 0: not counted, `err_cnt`++. The word still enters the FIFO; the controller does not police the FIFO.
- A mailbox write and the timeout in the same cycle: mailbox wins.
- Core writes to other addresses are ignored.
- Counters saturate at 2^32-1.
- `reset` mid-operation returns to IDLE next edge and clears all counters, `pkt_len` and `head_addr`. The FIFO must be reset in the same cycle.

## Timing
- Reset values:
  - `in_rdy` = 0, `fifo_reb` = 0, `out_wr` = 0, `pc_en` = 0, `core_reset` = 1.
  - `head_addr` = 0, `pkt_len` = 0, all counters = 0.
  - `in_rdy` rises the cycle after `reset` deasserts.
- `in_rdy`, `fifo_reb` and `out_wr` are combinational from state and inputs.
- `pc_en` and `core_reset` are registered.
- EOP accepted at edge N -> `in_rdy` low from cycle N+1; `pc_en` = 1 and `core_reset` = 0 from cycle N+1.
- Mailbox write sampled at edge M -> `pc_en` = 0 and `core_reset` = 1 at M+1; first `fifo_reb` possible in cycle M+1.
- DRAIN at full rate: one word per cycle, `pkt_len` cycles.
- Timeout: PROC lasts exactly TIMEOUT_CYCLES cycles when no mailbox write arrives.

## Structure
- Package `pkt_ctrl_pkg` holds:
  - the state enum (IDLE, RECV, PROC, DRAIN, DROP);
  - mailbox bit positions (`MBOX_FWD` = 0, `MBOX_DROP` = 1);
  - the saturating-counter width (32).
- Sub-module `pkt_framer`: SOP/EOP detection, `pkt_len` counting, write pointer and `head_addr` latch. The top level holds the FSM, timeout counter and statistics.

## Test plan
- 2 header words (ctrl FF) + 3 payload (ctrl 00) + EOP (ctrl 0F); core writes 64'h1 to 10'h3FF -> exactly 6 `out_wr` pulses, `pkt_cnt` = 1, `head_addr` = 0, `pkt_len` = 6.
- Same packet, mailbox write 64'h2 -> `fifo_empty` returns high, `out_wr` never asserts, `drop_cnt` = 1.
- No mailbox write -> `pc_en` high exactly 4096 cycles, then DROP, `drop_cnt` = 1.
- `out_rdy` toggling 1/0 every cycle during DRAIN of a 6-word packet -> 6 `out_wr` pulses over 11 cycles, data order preserved.
- 1000 payload words with no EOP -> truncated to PROC, `err_cnt` = 1; `in_wr` held during PROC -> `err_cnt` increments per word.
- `reset` pulse during PROC -> next cycle `pc_en` = 0, `core_reset` = 1, all counters 0, state IDLE.
